// File: rtl/trap_sequencer_if.sv
// Bundle of exception/interrupt events in and redirect/status results out
// of trap_sequencer; the slave side is the sequencer itself.
interface trap_sequencer_if;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_epc;
  logic        irq_req;
  logic [31:0] irq_epc;
  logic        eret;
  logic        status_we;
  logic [31:0] status_wdata;

  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        irq_ack;
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        double_fault;

  modport slave (
    input  exc_valid, exc_cause, exc_epc, irq_req, irq_epc, eret,
           status_we, status_wdata,
    output pc_redirect, redirect_pc, flush, irq_ack, status, epc, cause,
           double_fault
  );

  modport master (
    output exc_valid, exc_cause, exc_epc, irq_req, irq_epc, eret,
           status_we, status_wdata,
    input  pc_redirect, redirect_pc, flush, irq_ack, status, epc, cause,
           double_fault
  );
endinterface

// File: rtl/trap_sequencer.sv
// Turns exception/interrupt/eret events into a one-cycle PC redirect plus
// flush, and keeps IE/EXL, a private EPC/cause copy and a sticky double fault.
//
// state      | meaning
// ST_RUN     | normal execution, EXL=0, exceptions and enabled irqs accepted
// ST_TRAP    | redirect to handler issued this cycle, inputs ignored
// ST_HANDLER | handler running, EXL=1, irqs masked, nested exc = double fault
// ST_RET     | redirect to saved EPC issued this cycle, inputs ignored
module trap_sequencer #(
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0080,
  parameter bit          VECTORED     = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  trap_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRAP    = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RET     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic        df_q, df_d;
  logic        redirect_q, redirect_d;
  logic        ack_q, ack_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] rpc_q, rpc_d;

  // Only the low cause byte selects a vector; the add wraps mod 2^32.
  function automatic logic [31:0] target(input logic [7:0] code);
    if (VECTORED) return HANDLER_BASE + {24'b0, code};
    return HANDLER_BASE;
  endfunction

  logic unused_wdata;
  assign unused_wdata = ^bus.status_wdata[31:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      df_q       <= 1'b0;
      redirect_q <= 1'b0;
      ack_q      <= 1'b0;
      epc_q      <= 32'h0;
      cause_q    <= 32'h0;
      rpc_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      df_q       <= df_d;
      redirect_q <= redirect_d;
      ack_q      <= ack_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      rpc_q      <= rpc_d;
    end
  end

  // Outputs are computed one cycle early so every pulse leaves a flop.
  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    df_d       = df_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    redirect_d = 1'b0;
    ack_d      = 1'b0;
    rpc_d      = 32'h0;

    case (state_q)
      ST_RUN: begin
        if (bus.status_we) ie_d = bus.status_wdata[0];
        if (bus.exc_valid) begin
          state_d    = ST_TRAP;
          epc_d      = bus.exc_epc;
          cause_d    = bus.exc_cause;
          exl_d      = 1'b1;
          redirect_d = 1'b1;
          rpc_d      = target(bus.exc_cause[7:0]);
        end else if (bus.irq_req && ie_q) begin
          state_d    = ST_TRAP;
          epc_d      = bus.irq_epc;
          cause_d    = 32'h0;
          exl_d      = 1'b1;
          redirect_d = 1'b1;
          ack_d      = 1'b1;
          rpc_d      = target(8'h00);
        end
      end
      ST_TRAP: state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (bus.status_we) ie_d = bus.status_wdata[0];
        if (bus.exc_valid) begin
          // Nested fault keeps the original EPC/cause so eret still returns.
          state_d    = ST_TRAP;
          df_d       = 1'b1;
          redirect_d = 1'b1;
          rpc_d      = target(bus.exc_cause[7:0]);
        end else if (bus.eret) begin
          state_d    = ST_RET;
          exl_d      = 1'b0;
          redirect_d = 1'b1;
          rpc_d      = epc_q;
        end
      end
      ST_RET:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.pc_redirect  = redirect_q;
  assign bus.flush        = redirect_q;
  assign bus.redirect_pc  = rpc_q;
  assign bus.irq_ack      = ack_q;
  assign bus.status       = {30'b0, exl_q, ie_q};
  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.double_fault = df_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a plain-rules model checked every cycle
// against a non-vectored and a vectored (wrapping base) instance, plus literals.
module tb_trap_sequencer;
  localparam logic [31:0] BASE  = 32'h0000_0080;
  localparam logic [31:0] VBASE = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_sequencer_if ifc ();
  trap_sequencer_if ifv ();

  trap_sequencer #(.HANDLER_BASE(BASE), .VECTORED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
  );
  trap_sequencer #(.HANDLER_BASE(VBASE), .VECTORED(1'b1)) dut_v (
    .clk(clk), .rst_n(rst_n), .bus(ifv.slave)
  );

  assign ifv.exc_valid    = ifc.exc_valid;
  assign ifv.exc_cause    = ifc.exc_cause;
  assign ifv.exc_epc      = ifc.exc_epc;
  assign ifv.irq_req      = ifc.irq_req;
  assign ifv.irq_epc      = ifc.irq_epc;
  assign ifv.eret         = ifc.eret;
  assign ifv.status_we    = ifc.status_we;
  assign ifv.status_wdata = ifc.status_wdata;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural registers plus "what the next cycle shows".
  bit          m_ie = 0, m_exl = 0, m_df = 0, m_red = 0, m_ack = 0;
  logic [31:0] m_epc = 0, m_cause = 0, m_rpc = 0, m_rpcv = 0;

  always @(posedge clk) begin
    bit          busy;
    bit          new_ie;
    logic [31:0] c;
    if (!rst_n) begin
      m_ie = 0; m_exl = 0; m_df = 0; m_red = 0; m_ack = 0;
      m_epc = 0; m_cause = 0; m_rpc = 0; m_rpcv = 0;
    end else begin
      busy   = m_red;
      new_ie = m_ie;
      m_red  = 0; m_ack = 0; m_rpc = 0; m_rpcv = 0;
      if (!busy) begin
        if (ifc.status_we) new_ie = ifc.status_wdata[0];
        c = ifc.exc_cause;
        if (!m_exl) begin
          if (ifc.exc_valid) begin
            m_epc = ifc.exc_epc; m_cause = c; m_exl = 1; m_red = 1;
            m_rpc = BASE; m_rpcv = VBASE + (c & 32'hFF);
          end else if (ifc.irq_req && m_ie) begin
            m_epc = ifc.irq_epc; m_cause = 0; m_exl = 1; m_red = 1; m_ack = 1;
            m_rpc = BASE; m_rpcv = VBASE;
          end
        end else begin
          if (ifc.exc_valid) begin
            m_df = 1; m_red = 1;
            m_rpc = BASE; m_rpcv = VBASE + (c & 32'hFF);
          end else if (ifc.eret) begin
            m_exl = 0; m_red = 1; m_rpc = m_epc; m_rpcv = m_epc;
          end
        end
        m_ie = new_ie;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc_redirect", ifc.pc_redirect, m_red);
      chk("flush", ifc.flush, m_red);
      chk("redirect_pc", ifc.redirect_pc, m_rpc);
      chk("irq_ack", ifc.irq_ack, m_ack);
      chk("status", ifc.status, {30'b0, m_exl, m_ie});
      chk("epc", ifc.epc, m_epc);
      chk("cause", ifc.cause, m_cause);
      chk("double_fault", ifc.double_fault, m_df);
      chk("v_pc_redirect", ifv.pc_redirect, m_red);
      chk("v_redirect_pc", ifv.redirect_pc, m_rpcv);
      chk("v_irq_ack", ifv.irq_ack, m_ack);
      chk("v_status", ifv.status, {30'b0, m_exl, m_ie});
      chk("v_double_fault", ifv.double_fault, m_df);
    end
  end

  task automatic clr();
    ifc.exc_valid = 0; ifc.exc_cause = 0; ifc.exc_epc = 0;
    ifc.irq_req = 0; ifc.irq_epc = 0; ifc.eret = 0;
    ifc.status_we = 0; ifc.status_wdata = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exc(input logic [31:0] c, input logic [31:0] pc);
    ifc.exc_valid = 1; ifc.exc_cause = c; ifc.exc_epc = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    clr();
    rst_n = 0;
    cyc(1);
    cmp_en = 1;
    chk("rst_redirect", ifc.pc_redirect, 0);
    chk("rst_redirect_pc", ifc.redirect_pc, 0);
    chk("rst_status", ifc.status, 0);
    cyc(1);
    rst_n = 1;

    // Basic exception and return
    exc(32'h20, 32'h100); cyc(1); clr();
    chk("t1_redirect", ifc.pc_redirect, 1);
    chk("t1_flush", ifc.flush, 1);
    chk("t1_pc", ifc.redirect_pc, 32'h80);
    chk("t1_status", ifc.status, 2);
    chk("t1_epc", ifc.epc, 32'h100);
    chk("t1_vpc", ifv.redirect_pc, 32'h10);
    cyc(1);
    ifc.eret = 1; cyc(1); clr();
    chk("t1_ret_pc", ifc.redirect_pc, 32'h100);
    chk("t1_ret_status", ifc.status, 0);
    cyc(1);
    chk("t1_run_redirect", ifc.pc_redirect, 0);

    // Interrupt with IE=1
    ifc.status_we = 1; ifc.status_wdata = 1; cyc(1); clr();
    chk("t2_ie", ifc.status, 1);
    ifc.irq_req = 1; ifc.irq_epc = 32'h204; cyc(1);
    chk("t2_ack", ifc.irq_ack, 1);
    chk("t2_cause", ifc.cause, 0);
    chk("t2_epc", ifc.epc, 32'h204);
    chk("t2_vpc", ifv.redirect_pc, VBASE);
    cyc(2);
    chk("t2_masked_redirect", ifc.pc_redirect, 0);
    ifc.irq_req = 0; ifc.eret = 1; cyc(1); clr();
    chk("t2_ret_pc", ifc.redirect_pc, 32'h204);
    cyc(1);

    // IE=0: held interrupt must not be taken
    ifc.status_we = 1; ifc.status_wdata = 0; cyc(1); clr();
    ifc.irq_req = 1; ifc.irq_epc = 32'h208;
    cnt = 0;
    repeat (10) begin cyc(1); if (ifc.pc_redirect) cnt++; end
    clr();
    chk("t3_ie0_redirects", cnt, 0);

    // Double fault; status write during TRAP is ignored
    exc(32'h24, 32'h400); cyc(1); clr();
    ifc.status_we = 1; ifc.status_wdata = 1; cyc(1); clr();
    chk("t4_trap_we_ignored", ifc.status, 2);
    exc(32'h30, 32'h300); cyc(1); clr();
    chk("t4_df_pc", ifc.redirect_pc, 32'h80);
    chk("t4_df", ifc.double_fault, 1);
    chk("t4_df_epc", ifc.epc, 32'h400);
    chk("t4_df_cause", ifc.cause, 32'h24);
    chk("t4_df_vpc", ifv.redirect_pc, 32'h20);
    cyc(1);
    ifc.eret = 1; cyc(1); clr();
    chk("t4_ret_pc", ifc.redirect_pc, 32'h400);
    cyc(1);

    // Simultaneous exc/irq/eret, then reset during TRAP
    ifc.status_we = 1; ifc.status_wdata = 1; cyc(1); clr();
    exc(32'h28, 32'h500); ifc.irq_req = 1; ifc.irq_epc = 32'h600; ifc.eret = 1;
    cyc(1); clr();
    chk("t5_ack", ifc.irq_ack, 0);
    chk("t5_cause", ifc.cause, 32'h28);
    chk("t5_epc", ifc.epc, 32'h500);
    chk("t5_vpc_wrap", ifv.redirect_pc, 32'h18);
    rst_n = 0; cyc(1); rst_n = 1;
    chk("t5_rst_redirect", ifc.pc_redirect, 0);
    chk("t5_rst_pc", ifc.redirect_pc, 0);
    chk("t5_rst_df", ifc.double_fault, 0);
    chk("t5_rst_status", ifc.status, 0);
    ifc.eret = 1; cyc(1); clr();
    chk("t5_eret_after_rst", ifc.pc_redirect, 0);
    cyc(1);

    // Reset during HANDLER after a double fault
    exc(32'h20, 32'h700); cyc(1); clr(); cyc(1);
    exc(32'h24, 32'h704); cyc(1); clr();
    chk("t6_df", ifc.double_fault, 1);
    cyc(1);
    rst_n = 0; cyc(1); rst_n = 1;
    chk("t6_rst_df", ifc.double_fault, 0);
    chk("t6_rst_epc", ifc.epc, 0);
    chk("t6_rst_status", ifc.status, 0);
    ifc.eret = 1; cyc(1); clr();
    chk("t6_eret_after_rst", ifc.pc_redirect, 0);
    cyc(1);

    // Interrupt taken in the first RUN cycle after RET
    ifc.status_we = 1; ifc.status_wdata = 1; cyc(1); clr();
    exc(32'h20, 32'h800); cyc(1); clr(); cyc(1);
    ifc.eret = 1; ifc.irq_req = 1; ifc.irq_epc = 32'h804; cyc(1);
    ifc.eret = 0;
    chk("t7_ret_pc", ifc.redirect_pc, 32'h800);
    cyc(1);
    chk("t7_run_redirect", ifc.pc_redirect, 0);
    cyc(1); clr();
    chk("t7_ack", ifc.irq_ack, 1);
    chk("t7_epc", ifc.epc, 32'h804);
    cyc(1);
    ifc.eret = 1; cyc(1); clr();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Control-flow side of the exception path. The exception unit records cause and EPC. This block consumes those events and produces the actual redirect:
- steers the PC to the handler and flushes the pipeline;
- keeps the status bits (interrupt enable, exception level) and a private EPC/cause copy;
- returns to the saved EPC on `eret`.

It sits between the exception unit/decoder and the PC-select mux.

## Interface
Parameters:
- `HANDLER_BASE`, default 32'h0000_0080: handler entry address.
- `VECTORED`, default 0: when 1, target = `HANDLER_BASE + {24'b0, cause[7:0]}`; when 0, target = `HANDLER_BASE`.

Ports:
- `clk`  in  1  clock. Everything updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous and active-low.
- `exc_valid`  in  1  synchronous exception raised by the retiring instruction.
- `exc_cause`  in  32  cause code from the exception unit (0x20 syscall, 0x24 break/div0, 0x28 undefined, 0x30 overflow).
- `exc_epc`  in  32  faulting PC.
- `irq_req`  in  1  external interrupt, level-sensitive.
- `irq_epc`  in  32  resume address for an interrupt (pc_plus4 of the retiring instruction).
- `eret`  in  1  exception-return instruction retiring.
- `status_we`  in  1  write to the status register.
- `status_wdata`  in  32  status write data. Only bit0 (IE) is used.
- `pc_redirect`  out  1  PC mux selects `redirect_pc` this cycle.
- `redirect_pc`  out  32  redirect target.
- `flush`  out  1  squash the in-flight instruction.
- `irq_ack`  out  1  one-cycle pulse when an interrupt is taken.
- `status`  out  32  {30'b0, EXL, IE}.
- `epc`  out  32  saved EPC.
- `cause`  out  32  saved cause.
- `double_fault`  out  1  sticky; set when an exception occurs while EXL=1.

## Operation
States are RUN, TRAP, HANDLER and RET.

RUN (EXL=0). First match wins:
- `exc_valid`: go to TRAP. Latch epc←`exc_epc`, cause←`exc_cause`, EXL←1.
- `irq_req & IE`: go to TRAP. Latch epc←`irq_epc`, cause←0, EXL←1. `irq_ack` is asserted in TRAP.
- `eret`: ignored (no state change, no redirect).

TRAP (one cycle):
- Outputs: `pc_redirect`=1, `flush`=1, `redirect_pc`=handler target computed from the latched cause.
- All inputs are ignored (the instruction is flushed).
- Next state: HANDLER.

HANDLER (EXL=1). First match wins:
- `exc_valid`: go to TRAP. Set `double_fault`. epc and cause are NOT updated. The target is computed from the incoming `exc_cause`.
- `eret`: go to RET. EXL←0.
- `irq_req` is ignored while EXL=1.

RET (one cycle):
- Outputs: `pc_redirect`=1, `flush`=1, `redirect_pc`=epc.
- Inputs are ignored.
- Next state: RUN.

Status register:
- `status_we` in RUN or HANDLER writes IE←`status_wdata[0]`.
- The write is ignored in TRAP and RET. Writes to EXL are ignored.
- If a write and a trap happen in the same cycle, both take effect. The new IE governs interrupts from the next cycle on.

## Timing
- Reset (`rst_n`=0 at an edge): state RUN, IE=0, EXL=0, epc=0, cause=0, `double_fault`=0. All outputs are 0, including `redirect_pc`=0.
- Reset asserted in any state aborts to RUN within the same edge. No redirect is issued afterwards.
- Trap latency: event sampled at edge N. TRAP outputs are valid during cycle N+1. HANDLER begins at cycle N+2.
- Return latency: `eret` sampled at edge M. RET outputs during cycle M+1. `status`[1]=0 from M+1. RUN begins at M+2.
- `pc_redirect`, `flush` and `irq_ack` are single-cycle pulses and are registered.
- `redirect_pc` holds 0 whenever `pc_redirect`=0.
- A new interrupt can be taken at the earliest 1 cycle after RET, i.e. the first RUN cycle.
- Target addition is 32-bit and wraps modulo 2^32.

## Test plan
- Reset, then `exc_valid` with cause 0x20, epc 0x0000_0100 (VECTORED=0) → next cycle `pc_redirect`=1, `flush`=1, `redirect_pc`=0x80, `status`=2, `epc`=0x100. Then `eret` → next cycle `redirect_pc`=0x100, `status`=0, then RUN.
- IE=1 via `status_we`, `irq_req`=1, `irq_epc`=0x204 → TRAP with `irq_ack`=1, `cause`=0, `epc`=0x204. With IE=0, `irq_req` held 10 cycles → no redirect.
- In HANDLER, `exc_valid` with cause 0x30, epc 0x300 → redirect to 0x80, `double_fault`=1, `epc`/`cause` unchanged. `eret` → returns to the original epc.
- Same cycle: `exc_valid`, `irq_req` (IE=1) and `eret` in RUN → exception path taken, `irq_ack`=0, cause=`exc_cause`.
- VECTORED=1, HANDLER_BASE=0xFFFF_FFF0, cause 0x28 → `redirect_pc`=0x0000_0018 (wrap-around).
- `rst_n` dropped during TRAP and during HANDLER → next cycle all outputs 0, state RUN, `double_fault` cleared. An `eret` afterwards produces no redirect.
